dcache_sram_nway: RTL and testbench

Parametrised N-way set-associative data-cache storage array: tag, valid, dirty and data per line, true-LRU replacement, byte-masked write hits, block fills from memory, victim reporting and a sequential write-back flush engine. Sits between the D-cache controller FSM (issues lookups, fills, flushes) and the memory-side write-back path. Default parameters reproduce the current 2-set, 3-bit-tag, 8-byte-block geometry at 4 ways.

---
 rtl/dcache_sram_nway_if.sv | 42 ++++
 rtl/dcache_sram_nway.sv | 204 ++++++++++++++++++++
 tb/tb_dcache_sram_nway.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_sram_nway_if.sv
// Lookup, fill, flush and write-back bus between the D-cache controller and the
// N-way storage array.
interface dcache_sram_nway_if #(
   parameter int unsigned TAG_BITS       = 3,
   parameter int unsigned SET_INDEX_BITS = 1,
   parameter int unsigned BLOCK_BYTES    = 8
);
   localparam int unsigned ADDR_BITS  = TAG_BITS + SET_INDEX_BITS;
   localparam int unsigned BLOCK_BITS = 8 * BLOCK_BYTES;

   logic                   ren;
   logic                   wen;
   logic                   memWen;
   logic [BLOCK_BYTES-1:0] bytesAccess;
   logic [ADDR_BITS-1:0]   blockAddr;
   logic [BLOCK_BITS-1:0]  dataIn;
   logic                   hit;
   logic                   dirtyBit;
   logic [BLOCK_BITS-1:0]  dataOut;
   logic                   victimValid;
   logic [ADDR_BITS-1:0]   victimAddr;
   logic [BLOCK_BITS-1:0]  victimData;
   logic                   flushReq;
   logic                   flushBusy;
   logic                   flushDone;
   logic                   wbValid;
   logic                   wbReady;
   logic [ADDR_BITS-1:0]   wbAddr;
   logic [BLOCK_BITS-1:0]  wbData;

   modport master (
      output ren, wen, memWen, bytesAccess, blockAddr, dataIn, flushReq, wbReady,
      input  hit, dirtyBit, dataOut, victimValid, victimAddr, victimData,
             flushBusy, flushDone, wbValid, wbAddr, wbData
   );

   modport slave (
      input  ren, wen, memWen, bytesAccess, blockAddr, dataIn, flushReq, wbReady,
      output hit, dirtyBit, dataOut, victimValid, victimAddr, victimData,
             flushBusy, flushDone, wbValid, wbAddr, wbData
   );
endinterface

// File: rtl/dcache_sram_nway.sv
// N-way set-associative D-cache storage: tag/valid/dirty/data per line, true-LRU
// ages, byte-masked write hits, block fills, victim reporting and a write-back flush.
module dcache_sram_nway #(
   parameter int unsigned WAYS           = 4,
   parameter int unsigned SET_INDEX_BITS = 1,
   parameter int unsigned TAG_BITS       = 3,
   parameter int unsigned BLOCK_BYTES    = 8
) (
   input logic               clk,
   input logic               rst,
   dcache_sram_nway_if.slave bus
);
   localparam int unsigned SETS       = 1 << SET_INDEX_BITS;
   localparam int unsigned BLOCK_BITS = 8 * BLOCK_BYTES;
   localparam int unsigned WAY_BITS   = $clog2(WAYS);
   localparam int unsigned IDX_BITS   = SET_INDEX_BITS + WAY_BITS;
   localparam int unsigned ENTRIES    = SETS * WAYS;

   typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

   logic [TAG_BITS-1:0]   tag_q   [SETS][WAYS];
   logic [BLOCK_BITS-1:0] data_q  [SETS][WAYS];
   logic [WAY_BITS-1:0]   age_q   [SETS][WAYS];
   logic [WAYS-1:0]       valid_q [SETS];
   logic [WAYS-1:0]       dirty_q [SETS];

   state_t                state;
   logic [IDX_BITS-1:0]   idx;
   logic                  flush_busy;
   logic                  flush_done;
   logic                  wb_valid;
   logic [TAG_BITS+SET_INDEX_BITS-1:0] wb_addr;
   logic [BLOCK_BITS-1:0] wb_data;

   logic [SET_INDEX_BITS-1:0] set_sel;
   logic [TAG_BITS-1:0]       tag_sel;
   logic [SET_INDEX_BITS-1:0] scan_set;
   logic [WAY_BITS-1:0]       scan_way;
   logic                      last_entry;

   logic                  hit_any;
   logic [WAY_BITS-1:0]   hit_way;
   logic                  inv_any;
   logic [WAY_BITS-1:0]   inv_way;
   logic [WAY_BITS-1:0]   lru_way;
   logic [WAY_BITS-1:0]   vic_way;
   logic [WAY_BITS-1:0]   fill_way;
   logic [WAY_BITS-1:0]   touch_way;
   logic [BLOCK_BITS-1:0] merged;
   logic                  hit_eff;
   logic                  do_fill;
   logic                  do_write;
   logic                  do_read;

   assign set_sel    = bus.blockAddr[SET_INDEX_BITS-1:0];
   assign tag_sel    = bus.blockAddr[TAG_BITS+SET_INDEX_BITS-1:SET_INDEX_BITS];
   assign scan_set   = idx[IDX_BITS-1:WAY_BITS];
   assign scan_way   = idx[WAY_BITS-1:0];
   assign last_entry = (idx == IDX_BITS'(ENTRIES - 1));

   // Tag match, first invalid way and the way whose age marks it least recent.
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      lru_way = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[set_sel][WAY_BITS'(w)] && (tag_q[set_sel][WAY_BITS'(w)] == tag_sel)
             && !hit_any) begin
            hit_any = 1'b1;
            hit_way = WAY_BITS'(w);
         end
         if (!valid_q[set_sel][WAY_BITS'(w)] && !inv_any) begin
            inv_any = 1'b1;
            inv_way = WAY_BITS'(w);
         end
         if (age_q[set_sel][WAY_BITS'(w)] == WAY_BITS'(WAYS - 1)) begin
            lru_way = WAY_BITS'(w);
         end
      end
   end

   assign vic_way   = inv_any ? inv_way : lru_way;
   assign fill_way  = hit_any ? hit_way : vic_way;

   assign do_fill   = bus.memWen && !flush_busy;
   assign do_write  = bus.wen && !bus.memWen && !flush_busy && hit_any;
   assign do_read   = bus.ren && !bus.wen && !bus.memWen && !flush_busy && hit_any;
   assign touch_way = do_fill ? fill_way : hit_way;

   always_comb begin
      merged = data_q[set_sel][hit_way];
      for (int unsigned b = 0; b < BLOCK_BYTES; b++) begin
         if (bus.bytesAccess[b]) begin
            merged[8*b +: 8] = bus.dataIn[8*b +: 8];
         end
      end
   end

   assign hit_eff         = hit_any && !flush_busy;
   assign bus.hit         = hit_eff;
   assign bus.dataOut     = hit_eff ? data_q[set_sel][hit_way] : '0;
   assign bus.dirtyBit    = hit_any ? dirty_q[set_sel][hit_way] : dirty_q[set_sel][vic_way];
   assign bus.victimValid = !flush_busy && valid_q[set_sel][vic_way];
   assign bus.victimAddr  = {tag_q[set_sel][vic_way], set_sel};
   assign bus.victimData  = data_q[set_sel][vic_way];

   assign bus.flushBusy = flush_busy;
   assign bus.flushDone = flush_done;
   assign bus.wbValid   = wb_valid;
   assign bus.wbAddr    = wb_addr;
   assign bus.wbData    = wb_data;

   // Tag and data arrays carry no reset; valid bits gate every use of them.
   always_ff @(posedge clk) begin
      if (do_fill) begin
         data_q[set_sel][fill_way] <= bus.dataIn;
         tag_q[set_sel][fill_way]  <= tag_sel;
      end else if (do_write) begin
         data_q[set_sel][hit_way] <= merged;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            valid_q[SET_INDEX_BITS'(s)] <= '0;
            dirty_q[SET_INDEX_BITS'(s)] <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
               age_q[SET_INDEX_BITS'(s)][WAY_BITS'(w)] <= WAY_BITS'(w);
            end
         end
         state      <= IDLE;
         idx        <= '0;
         flush_busy <= 1'b0;
         flush_done <= 1'b0;
         wb_valid   <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
      end else begin
         flush_done <= 1'b0;

         if (do_fill) begin
            valid_q[set_sel][fill_way] <= 1'b1;
            dirty_q[set_sel][fill_way] <= 1'b0;
         end else if (do_write) begin
            dirty_q[set_sel][hit_way] <= 1'b1;
         end

         // Touched way becomes MRU; only ways younger than it age by one.
         if (do_fill || do_write || do_read) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               if (WAY_BITS'(w) == touch_way) begin
                  age_q[set_sel][WAY_BITS'(w)] <= '0;
               end else if (age_q[set_sel][WAY_BITS'(w)] < age_q[set_sel][touch_way]) begin
                  age_q[set_sel][WAY_BITS'(w)] <= age_q[set_sel][WAY_BITS'(w)] + 1'b1;
               end
            end
         end

         case (state)
            IDLE: begin
               if (bus.flushReq) begin
                  state      <= SCAN;
                  idx        <= '0;
                  flush_busy <= 1'b1;
               end
            end
            SCAN: begin
               if (valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) begin
                  state    <= WB;
                  wb_valid <= 1'b1;
                  wb_addr  <= {tag_q[scan_set][scan_way], scan_set};
                  wb_data  <= data_q[scan_set][scan_way];
               end else if (last_entry) begin
                  state      <= DONE;
                  flush_done <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            WB: begin
               if (bus.wbReady) begin
                  wb_valid                    <= 1'b0;
                  dirty_q[scan_set][scan_way] <= 1'b0;
                  if (last_entry) begin
                     state      <= DONE;
                     flush_done <= 1'b1;
                  end else begin
                     state <= SCAN;
                     idx   <= idx + 1'b1;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               flush_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed bench for dcache_sram_nway at default geometry (4 ways, 2 sets, 3-bit tag,
// 8-byte blocks); expected values are hand-computed constants.
module tb_dcache_sram_nway;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   dcache_sram_nway_if #(.TAG_BITS(3), .SET_INDEX_BITS(1), .BLOCK_BYTES(8)) bus ();

   dcache_sram_nway #(
      .WAYS(4), .SET_INDEX_BITS(1), .TAG_BITS(3), .BLOCK_BYTES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic fill(input logic [3:0] addr, input logic [63:0] d);
      bus.blockAddr = addr;
      bus.dataIn    = d;
      bus.memWen    = 1'b1;
      tick();
      bus.memWen    = 1'b0;
   endtask

   task automatic write(input logic [3:0] addr, input logic [7:0] mask, input logic [63:0] d);
      bus.blockAddr   = addr;
      bus.bytesAccess = mask;
      bus.dataIn      = d;
      bus.wen         = 1'b1;
      tick();
      bus.wen         = 1'b0;
   endtask

   task automatic look(input logic [3:0] addr);
      bus.blockAddr = addr;
      #1;
   endtask

   logic [3:0]  hs_addr [2];
   logic [63:0] hs_data [2];
   logic [3:0]  held_addr;
   logic [63:0] held_data;
   int          hs;
   int          done_at;
   int          done_cnt;
   int          hit_seen;
   int          n;

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.ren = 1'b0; bus.wen = 1'b0; bus.memWen = 1'b0;
      bus.bytesAccess = '0; bus.blockAddr = '0; bus.dataIn = '0;
      bus.flushReq = 1'b0; bus.wbReady = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      bus.ren = 1'b1;
      look(4'b0000);
      chk("rst_hit", 64'(bus.hit), 64'd0);
      chk("rst_dirty", 64'(bus.dirtyBit), 64'd0);
      chk("rst_victim", 64'(bus.victimValid), 64'd0);
      chk("rst_data", bus.dataOut, 64'd0);
      chk("rst_busy", 64'(bus.flushBusy), 64'd0);
      chk("rst_done", 64'(bus.flushDone), 64'd0);
      chk("rst_wbvalid", 64'(bus.wbValid), 64'd0);
      bus.ren = 1'b0;

      // Fill then byte-masked write hit
      fill(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF);
      look(4'b0000);
      chk("fill_hit", 64'(bus.hit), 64'd1);
      chk("fill_dirty", 64'(bus.dirtyBit), 64'd0);
      write(4'b0000, 8'hF0, 64'hAAAA_AAAA_0000_0000);
      look(4'b0000);
      chk("wr_hit", 64'(bus.hit), 64'd1);
      chk("wr_data", bus.dataOut, 64'hAAAA_AAAA_FFFF_FFFF);
      chk("wr_dirty", 64'(bus.dirtyBit), 64'd1);

      // LRU victim selection
      do_reset();
      fill(4'b0000, 64'h10);
      fill(4'b0010, 64'h11);
      fill(4'b0100, 64'h12);
      fill(4'b1000, 64'h13);
      bus.ren = 1'b1;
      bus.blockAddr = 4'b0000;
      tick();
      bus.ren = 1'b0;
      look(4'b1110);
      chk("lru_miss", 64'(bus.hit), 64'd0);
      chk("lru_vvalid", 64'(bus.victimValid), 64'd1);
      chk("lru_vaddr", 64'(bus.victimAddr), 64'h2);
      chk("lru_vdata", bus.victimData, 64'h11);
      fill(4'b1110, 64'h17);
      look(4'b0010);
      chk("evicted_miss", 64'(bus.hit), 64'd0);
      look(4'b0000);
      chk("kept_hit", 64'(bus.hit), 64'd1);
      look(4'b1110);
      chk("new_data", bus.dataOut, 64'h17);
      write(4'b1011, 8'hFF, 64'h99);
      look(4'b1011);
      chk("wmiss_hit", 64'(bus.hit), 64'd0);
      chk("wmiss_vvalid", 64'(bus.victimValid), 64'd0);

      // Flush with two dirty lines and one clean line
      do_reset();
      fill(4'b0000, 64'h0);
      write(4'b0000, 8'hFF, 64'h0123_4567_89AB_CDEF);
      fill(4'b0111, 64'hFEDC_BA98_7654_3210);
      write(4'b0111, 8'h0F, 64'h0000_0000_CAFE_F00D);
      fill(4'b0100, 64'h5555_5555_5555_5555);
      bus.wbReady  = 1'b1;
      bus.flushReq = 1'b1;
      tick();
      bus.flushReq = 1'b0;
      bus.ren = 1'b1;
      bus.blockAddr = 4'b0000;
      hs = 0; done_at = 0; done_cnt = 0; hit_seen = 0;
      for (int k = 1; k <= 13; k++) begin
         #1;
         if (bus.wbValid && bus.wbReady && hs < 2) begin
            hs_addr[hs] = bus.wbAddr;
            hs_data[hs] = bus.wbData;
            hs++;
         end
         if (bus.flushDone) begin
            done_cnt++;
            done_at = k;
         end
         if (k <= 11 && bus.hit) hit_seen = 1;
         tick();
      end
      bus.ren = 1'b0;
      chk("fl_hs_count", 64'(hs), 64'd2);
      chk("fl_addr0", 64'(hs_addr[0]), 64'h0);
      chk("fl_data0", hs_data[0], 64'h0123_4567_89AB_CDEF);
      chk("fl_addr1", 64'(hs_addr[1]), 64'h7);
      chk("fl_data1", hs_data[1], 64'hFEDC_BA98_CAFE_F00D);
      chk("fl_done_cycle", 64'(done_at), 64'd11);
      chk("fl_done_pulses", 64'(done_cnt), 64'd1);
      chk("fl_hit_blocked", 64'(hit_seen), 64'd0);
      chk("fl_busy_end", 64'(bus.flushBusy), 64'd0);
      look(4'b0000);
      chk("fl_a_hit", 64'(bus.hit), 64'd1);
      chk("fl_a_dirty", 64'(bus.dirtyBit), 64'd0);
      look(4'b0111);
      chk("fl_b_hit", 64'(bus.hit), 64'd1);
      chk("fl_b_dirty", 64'(bus.dirtyBit), 64'd0);
      look(4'b0100);
      chk("fl_clean_hit", 64'(bus.hit), 64'd1);

      // Write-back back-pressure
      write(4'b0000, 8'h01, 64'h55);
      bus.wbReady  = 1'b0;
      bus.flushReq = 1'b1;
      tick();
      bus.flushReq = 1'b0;
      n = 0;
      while (!bus.wbValid && n < 20) begin
         tick();
         n++;
      end
      chk("bp_wbvalid", 64'(bus.wbValid), 64'd1);
      held_addr = bus.wbAddr;
      held_data = bus.wbData;
      chk("bp_addr", 64'(held_addr), 64'h0);
      chk("bp_data", held_data, 64'h0123_4567_89AB_CD55);
      bus.ren = 1'b1;
      for (int k = 0; k < 5; k++) begin
         look(4'b0111);
         chk("bp_hold_valid", 64'(bus.wbValid), 64'd1);
         chk("bp_hold_addr", 64'(bus.wbAddr), 64'h0);
         chk("bp_hold_data", bus.wbData, 64'h0123_4567_89AB_CD55);
         chk("bp_hit_blocked", 64'(bus.hit), 64'd0);
         chk("bp_vic_blocked", 64'(bus.victimValid), 64'd0);
         tick();
      end
      bus.ren = 1'b0;
      bus.wbReady = 1'b1;
      tick();
      chk("bp_released", 64'(bus.wbValid), 64'd0);
      n = 0;
      while (!bus.flushDone && n < 20) begin
         tick();
         n++;
      end
      chk("bp_done", 64'(bus.flushDone), 64'd1);
      tick();
      bus.wbReady = 1'b0;
      look(4'b0000);
      chk("bp_a_dirty", 64'(bus.dirtyBit), 64'd0);
      chk("bp_a_data", bus.dataOut, 64'h0123_4567_89AB_CD55);

      // memWen beats wen
      bus.blockAddr   = 4'b0000;
      bus.dataIn      = 64'hDEAD_BEEF_0BAD_F00D;
      bus.bytesAccess = 8'hFF;
      bus.memWen = 1'b1; bus.wen = 1'b1; bus.ren = 1'b1;
      tick();
      bus.memWen = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0;
      look(4'b0000);
      chk("prio_hit", 64'(bus.hit), 64'd1);
      chk("prio_dirty", 64'(bus.dirtyBit), 64'd0);
      chk("prio_data", bus.dataOut, 64'hDEAD_BEEF_0BAD_F00D);

      // Reset during write-back
      write(4'b0000, 8'h01, 64'h77);
      look(4'b0000);
      chk("rwb_dirty", 64'(bus.dirtyBit), 64'd1);
      bus.flushReq = 1'b1;
      tick();
      bus.flushReq = 1'b0;
      n = 0;
      while (!bus.wbValid && n < 20) begin
         tick();
         n++;
      end
      chk("rwb_in_wb", 64'(bus.wbValid), 64'd1);
      do_reset();
      #1;
      chk("rwb_busy", 64'(bus.flushBusy), 64'd0);
      chk("rwb_wbvalid", 64'(bus.wbValid), 64'd0);
      look(4'b0000);
      chk("rwb_miss_a", 64'(bus.hit), 64'd0);
      look(4'b0111);
      chk("rwb_miss_b", 64'(bus.hit), 64'd0);
      look(4'b0100);
      chk("rwb_miss_c", 64'(bus.hit), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rwb_quiet", 64'(bus.wbValid), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
